// File: rtl/video_pkg.sv
// Shared video types, colour constants and the default 800x480 raster timing
// used by the display output path.
package video_pkg;

    parameter int HDISP  = 800;
    parameter int VDISP  = 480;
    parameter int HFP    = 40;
    parameter int HPULSE = 48;
    parameter int HBP    = 40;
    parameter int VFP    = 13;
    parameter int VPULSE = 3;
    parameter int VBP    = 29;
    parameter int GRID   = 16;

    typedef logic [23:0] rgb_t;

    localparam rgb_t RGB_BLACK    = 24'h000000;
    localparam rgb_t RGB_WHITE    = 24'hFFFFFF;
    localparam rgb_t RGB_UNDERRUN = 24'hFF00FF;

endpackage

// File: rtl/vga_timing_gen_sync_counter.sv
// One raster axis: a wrapping position counter with decoded display-region,
// active-low sync and end-of-axis (wrap) strobes.
module sync_counter #(
    parameter int TOTAL = 928,
    parameter int DISP  = 800,
    parameter int FP    = 40,
    parameter int PULSE = 48
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    output logic [$clog2(TOTAL)-1:0] cnt,
    output logic                     active,
    output logic                     sync_n,
    output logic                     wrap
);

    localparam int W  = $clog2(TOTAL);
    localparam int WX = W + 1;

    // Region bounds are one bit wider so a sync pulse ending exactly at TOTAL
    // (zero back porch) still fits.
    localparam logic [W-1:0]  LAST       = W'(TOTAL - 1);
    localparam logic [WX-1:0] DISP_END   = WX'(DISP);
    localparam logic [WX-1:0] SYNC_START = WX'(DISP + FP);
    localparam logic [WX-1:0] SYNC_END   = WX'(DISP + FP + PULSE);

    logic [W-1:0]  cnt_q, cnt_d;
    logic [WX-1:0] cnt_x;

    assign wrap  = en && (cnt_q == LAST);
    assign cnt_x = {1'b0, cnt_q};

    always_comb begin
        cnt_d = cnt_q;
        if (wrap) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign active = cnt_x < DISP_END;
    assign sync_n = !((cnt_x >= SYNC_START) && (cnt_x < SYNC_END));

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: HS/VS/BLANK timing plus a pixel path that forwards an
// upstream never-stalled stream or a built-in grid pattern.
module vga_timing_gen #(
    parameter int HDISP  = video_pkg::HDISP,
    parameter int VDISP  = video_pkg::VDISP,
    parameter int HFP    = video_pkg::HFP,
    parameter int HPULSE = video_pkg::HPULSE,
    parameter int HBP    = video_pkg::HBP,
    parameter int VFP    = video_pkg::VFP,
    parameter int VPULSE = video_pkg::VPULSE,
    parameter int VBP    = video_pkg::VBP,
    parameter int GRID   = video_pkg::GRID
) (
    input  logic        pixel_clk,
    input  logic        pixel_rst,
    input  logic        mode,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        sof,
    output logic        underrun,
    output logic        HS,
    output logic        VS,
    output logic        BLANK,
    output logic [23:0] RGB
);

    import video_pkg::*;

    localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
    localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;
    localparam int HW     = $clog2(HTOTAL);
    localparam int VW     = $clog2(VTOTAL);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_active, h_sync_n, h_wrap;
    logic          v_active, v_sync_n, v_wrap;

    sync_counter #(
        .TOTAL (HTOTAL),
        .DISP  (HDISP),
        .FP    (HFP),
        .PULSE (HPULSE)
    ) u_hcnt (
        .clk    (pixel_clk),
        .rst    (pixel_rst),
        .en     (1'b1),
        .cnt    (h_cnt),
        .active (h_active),
        .sync_n (h_sync_n),
        .wrap   (h_wrap)
    );

    sync_counter #(
        .TOTAL (VTOTAL),
        .DISP  (VDISP),
        .FP    (VFP),
        .PULSE (VPULSE)
    ) u_vcnt (
        .clk    (pixel_clk),
        .rst    (pixel_rst),
        .en     (h_wrap),
        .cnt    (v_cnt),
        .active (v_active),
        .sync_n (v_sync_n),
        .wrap   (v_wrap)
    );

    logic active, grid_hit, slot_miss;
    rgb_t rgb_d, rgb_q;
    logic underrun_d, underrun_q;
    logic hs_q, vs_q, blank_q, sof_q;
    // High exactly while the counters sit at (0,0): set by reset or by the
    // frame-end wrap, so it marks the same cycle an (h,v)==(0,0) decode would.
    logic origin_q;

    assign active    = h_active && v_active;
    assign pix_ready = mode && active;
    assign slot_miss = pix_ready && !pix_valid;
    assign grid_hit  = ((h_cnt & HW'(GRID - 1)) == '0) || ((v_cnt & VW'(GRID - 1)) == '0);

    always_comb begin
        rgb_d = RGB_BLACK;
        if (active) begin
            if (mode) begin
                rgb_d = pix_valid ? rgb_t'(pix_data) : RGB_UNDERRUN;
            end else begin
                rgb_d = grid_hit ? RGB_WHITE : RGB_BLACK;
            end
        end
    end

    // A new gap on the frame's first slot must survive the frame-start clear.
    always_comb begin
        underrun_d = underrun_q;
        if (slot_miss) begin
            underrun_d = 1'b1;
        end else if (origin_q) begin
            underrun_d = 1'b0;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) begin
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            blank_q    <= 1'b0;
            rgb_q      <= RGB_BLACK;
            sof_q      <= 1'b0;
            underrun_q <= 1'b0;
            origin_q   <= 1'b1;
        end else begin
            hs_q       <= h_sync_n;
            vs_q       <= v_sync_n;
            blank_q    <= active;
            rgb_q      <= rgb_d;
            sof_q      <= origin_q;
            underrun_q <= underrun_d;
            origin_q   <= v_wrap;
        end
    end

    assign HS       = hs_q;
    assign VS       = vs_q;
    assign BLANK    = blank_q;
    assign RGB      = rgb_q;
    assign sof      = sof_q;
    assign underrun = underrun_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the VGA raster timing (HS, VS, BLANK) and pixel stream for the video output port, directly upstream of the display sink on `video_if`. Inside `Top` it sits between the pixel source (framebuffer reader, ready/valid stream) and the external video interface. It also has a built-in grid test pattern, so the display path can be brought up without any upstream source.

## Interface

Parameters:
- `HDISP`, 800: active pixels per line.
- `VDISP`, 480: active lines per frame.
- `HFP` / `HPULSE` / `HBP`, 40 / 48 / 40: horizontal front porch / sync / back porch, in pixels.
- `VFP` / `VPULSE` / `VBP`, 13 / 3 / 29: vertical front porch / sync / back porch, in lines.
- `GRID`, 16: test-pattern grid pitch in pixels; must be a power of two.

Ports:
- `pixel_clk`, in, 1: pixel clock; the only clock.
- `pixel_rst`, in, 1: reset, synchronous, active-high.
- `mode`, in, 1: 0 = test pattern, 1 = upstream stream.
- `pix_data`, in, 24: upstream RGB888 pixel.
- `pix_valid`, in, 1: upstream pixel available.
- `pix_ready`, out, 1: block consumes `pix_data` this cycle.
- `sof`, out, 1: one-cycle pulse aligned with the first active pixel of a frame.
- `underrun`, out, 1: sticky flag; set if the stream was empty during a consume slot.
- `HS`, out, 1: horizontal sync, active low.
- `VS`, out, 1: vertical sync, active low.
- `BLANK`, out, 1: 1 inside the active area, 0 in blanking.
- `RGB`, out, 24: pixel colour; 0 whenever `BLANK` = 0.

## Operation

Counters:
- `HTOTAL = HDISP+HFP+HPULSE+HBP`; `VTOTAL = VDISP+VFP+VPULSE+VBP`.
- `h_cnt` counts 0..HTOTAL-1 and wraps to 0.
- `v_cnt` increments when `h_cnt` wraps. It counts 0..VTOTAL-1 and wraps to 0.
- Counter widths are `$clog2(HTOTAL)` and `$clog2(VTOTAL)`.

Regions, display first:
- Active when `h_cnt < HDISP` and `v_cnt < VDISP`.
- HS low when `HDISP+HFP <= h_cnt < HDISP+HFP+HPULSE`.
- VS low when `VDISP+VFP <= v_cnt < VDISP+VFP+VPULSE`.

Handshake:
- `pix_ready` is combinational and equals `mode && active(h_cnt, v_cnt)`.
- A transfer happens when `pix_ready && pix_valid`.
- If `pix_ready && !pix_valid`, that slot outputs 24'hFF00FF (magenta) and sets `underrun`.
- The stream is never stalled: missing pixels are not retried, and the raster never waits.

Other behaviour:
- Test pattern (`mode` = 0): white (24'hFFFFFF) when `h_cnt % GRID == 0` or `v_cnt % GRID == 0`, otherwise black.
- `underrun` clears on the cycle `sof` is registered, unless a new underrun occurs on that same cycle; the set wins.
- A `mode` change takes effect on the next cycle. The upstream source must realign on `sof`.

## Timing

Reset:
- While `pixel_rst` is high: `h_cnt` = `v_cnt` = 0, `HS` = `VS` = 1, `BLANK` = 0, `RGB` = 0, `sof` = 0, `underrun` = 0.
- The cycle after reset is released is counter state (0,0).

Latency and alignment:
- `HS`, `VS`, `BLANK`, `RGB` and `sof` are all registered, one cycle after the counter state they decode. They are mutually aligned with no skew.
- `pix_ready` is not registered: it is asserted on the counter cycle, and the accepted pixel appears on `RGB` one cycle later.
- `sof` is decoded from `h_cnt` = 0, `v_cnt` = 0.
- `v_cnt` and `h_cnt` wrap on the same edge at the frame end (HTOTAL-1, VTOTAL-1).

Mid-operation reset: any cycle of `pixel_rst` forces the reset values above on the next edge. No partial line is emitted after reset.

Frame length is exactly `HTOTAL*VTOTAL` cycles, with no dead cycles.

## Structure

- Package `video_pkg`:
  - timing defaults (HDISP…VBP) as parameters;
  - `typedef logic [23:0] rgb_t`;
  - colour constants `RGB_BLACK`, `RGB_WHITE`, `RGB_UNDERRUN`.
- One sub-module, `sync_counter`:
  - parameters TOTAL, DISP, FP, PULSE;
  - inputs `en`, clock and reset;
  - outputs `cnt`, `active`, `sync_n`, `wrap`.
- Instantiated twice; the horizontal `wrap` drives the vertical `en`.

## Test plan

Parameters HDISP=160, VDISP=90, others at default: HTOTAL=288, VTOTAL=135, 38880 cycles per frame.

- Timing, `mode`=0, release reset: `sof` pulses every 38880 cycles. The HS low pulse lasts 48 cycles and starts 200 cycles after the line starts. The VS low pulse lasts 3 lines.
- Line count, same setup: `BLANK` high for exactly 160 cycles per line, on 90 lines per frame.
- Test pattern, `mode`=0: pixels (0,y) and (x,0) are 24'hFFFFFF. Pixel (5,5) is 0. Pixel (16,7) is white. `RGB` = 0 whenever `BLANK` = 0.
- Stream, `mode`=1 with an always-valid counter source: 14400 transfers per frame, `RGB` equals the accepted data one cycle later, `underrun` stays 0.
- Underrun, `mode`=1: drop `pix_valid` for one active slot. That pixel is 24'hFF00FF and `underrun` rises. `underrun` clears at the next `sof` if no further gaps occur.
- Mid-frame reset: pulse `pixel_rst` for 1 cycle at (100,40). Outputs take their reset values. `sof` occurs exactly 1 cycle after reset is released.
